keypoint_collector: RTL and testbench

Receives the per-pixel keypoint stream produced by the FAST detector and packs flagged keypoints, with coordinates, score, cos and sin, into a FIFO. Each frame is closed with a terminator record, and the downstream descriptor/readout stage drains the FIFO through a valid/ready handshake. The block caps keypoints per frame, applies a minimum score, and reports kept and dropped counts.

---
 rtl/keypoint_collector.sv | 136 +++++++++++++
 tb/tb_keypoint_collector.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypoint_collector.sv
// Packs FAST keypoints into a FWFT FIFO and closes each frame with a terminator record.
// Define KPC_FRAME_STATS_EN to add the kept/dropped counts to the terminator and to enable o_drop.
module keypoint_collector #(
  parameter int         DEPTH     = 64,
  parameter int         MAX_KP    = 500,
  parameter logic [7:0] SCORE_MIN = 8'd0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_end,
  input  logic                     i_flag,
  input  logic [9:0]               i_x,
  input  logic [9:0]               i_y,
  input  logic [7:0]               i_score,
  input  logic [11:0]              i_cos,
  input  logic [11:0]              i_sin,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [51:0]              o_data,
  output logic                     o_eof,
  output logic [9:0]               o_count,
  output logic [9:0]               o_drop,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_KPMAX = LW'(DEPTH - 1);
  localparam logic [9:0]    KP_CAP    = 10'(MAX_KP);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_TERM} state_t;

  state_t        state_reg;
  logic [9:0]    count_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [52:0]   mem [DEPTH];

  logic          candidate;
  logic          room;
  logic          kp_push;
  logic          kp_drop;
  logic          term_push;
  logic          pop;
  logic          push;
  logic [51:0]   term_payload;
  logic [52:0]   wr_word;
  logic [52:0]   head_word;

  // A restart pulse takes priority over any pixel presented in the same cycle.
  always_comb begin
    candidate = (state_reg == S_FRAME) && !i_start && i_flag && (i_score >= SCORE_MIN);
    room      = (count_reg < KP_CAP) && (level_reg < LVL_KPMAX);
    kp_push   = candidate && room;
    kp_drop   = candidate && !room;
    term_push = (state_reg == S_TERM);
    pop       = (level_reg != '0) && i_ready;
    // Only a terminator can meet a full FIFO; it waits for nothing, so guard the write.
    push      = (kp_push || term_push) && ((level_reg != LVL_FULL) || pop);
    wr_word   = term_push ? {1'b1, term_payload}
                          : {1'b0, i_x, i_y, i_score, i_cos, i_sin};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else begin
      if (i_start) begin
        count_reg <= '0;
      end else if (kp_push) begin
        count_reg <= count_reg + 10'd1;
      end
      case (state_reg)
        S_IDLE:  if (i_start) state_reg <= S_FRAME;
        S_FRAME: if (!i_start && i_end) state_reg <= S_TERM;
        S_TERM:  state_reg <= i_start ? S_FRAME : S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef KPC_FRAME_STATS_EN
  logic [9:0] drop_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      drop_reg <= '0;
    end else if (kp_drop && (drop_reg != 10'h3FF)) begin
      drop_reg <= drop_reg + 10'd1;
    end
  end

  assign term_payload = {count_reg, drop_reg, 32'd0};
  assign o_drop       = drop_reg;
`else
  logic unused_drop;
  assign unused_drop  = kp_drop;
  assign term_payload = '0;
  assign o_drop       = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop) begin
        level_reg <= level_reg + LW'(1);
      end else if (!push && pop) begin
        level_reg <= level_reg - LW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg] <= wr_word;
  end

  // Head is gated so the outputs read as zero whenever the FIFO is empty.
  assign head_word = mem[rd_ptr_reg];
  assign o_valid   = (level_reg != '0);
  assign o_data    = o_valid ? head_word[51:0] : '0;
  assign o_eof     = o_valid && head_word[52];
  assign o_count   = count_reg;
  assign o_level   = level_reg;
  assign o_busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_keypoint_collector.sv
// Directed bench for keypoint_collector: three instances (default, MAX_KP=2, DEPTH=4/SCORE_MIN=30) share stimulus.
module tb_keypoint_collector;

`ifdef KPC_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, fin, flag, ready;
  logic [9:0]  x, y;
  logic [7:0]  score;
  logic [11:0] cs, sn;

  logic        a_valid, a_eof, a_busy;
  logic [51:0] a_data;
  logic [9:0]  a_count, a_drop;
  logic [6:0]  a_level;
  logic        b_valid, b_eof, b_busy;
  logic [51:0] b_data;
  logic [9:0]  b_count, b_drop;
  logic [3:0]  b_level;
  logic        c_valid, c_eof, c_busy;
  logic [51:0] c_data;
  logic [9:0]  c_count, c_drop;
  logic [2:0]  c_level;

  keypoint_collector u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_end(fin), .i_flag(flag),
    .i_x(x), .i_y(y), .i_score(score), .i_cos(cs), .i_sin(sn),
    .o_valid(a_valid), .i_ready(ready), .o_data(a_data), .o_eof(a_eof),
    .o_count(a_count), .o_drop(a_drop), .o_level(a_level), .o_busy(a_busy));

  keypoint_collector #(.DEPTH(8), .MAX_KP(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_end(fin), .i_flag(flag),
    .i_x(x), .i_y(y), .i_score(score), .i_cos(cs), .i_sin(sn),
    .o_valid(b_valid), .i_ready(ready), .o_data(b_data), .o_eof(b_eof),
    .o_count(b_count), .o_drop(b_drop), .o_level(b_level), .o_busy(b_busy));

  keypoint_collector #(.DEPTH(4), .SCORE_MIN(8'd30)) u_c (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_end(fin), .i_flag(flag),
    .i_x(x), .i_y(y), .i_score(score), .i_cos(cs), .i_sin(sn),
    .o_valid(c_valid), .i_ready(ready), .o_data(c_data), .o_eof(c_eof),
    .o_count(c_count), .o_drop(c_drop), .o_level(c_level), .o_busy(c_busy));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; fin = 1'b0; flag = 1'b0;
    x = '0; y = '0; score = '0; cs = '0; sn = '0;
  endtask

  task automatic do_reset();
    idle_in();
    ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic frame_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_pix(input logic [9:0] px, input logic [9:0] py, input logic [7:0] ps,
                         input logic [11:0] pc, input logic [11:0] pn);
    flag = 1'b1; x = px; y = py; score = ps; cs = pc; sn = pn;
  endtask

  function automatic logic [51:0] term(input logic [9:0] cnt, input logic [9:0] drp);
    return STATS ? {cnt, drp, 32'd0} : 52'd0;
  endfunction

  function automatic logic [9:0] dexp(input logic [9:0] d);
    return STATS ? d : 10'd0;
  endfunction

  initial begin
    idle_in();
    ready = 1'b0;
    rst = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", a_valid, 0);
    check("rst_eof",   a_eof,   0);
    check("rst_data",  a_data,  0);
    check("rst_count", a_count, 0);
    check("rst_drop",  a_drop,  0);
    check("rst_level", a_level, 0);
    check("rst_busy",  a_busy,  0);

    // Three keypoints streamed straight through, then the terminator
    ready = 1'b1;
    frame_start();
    check("t1_busy", a_busy, 1);
    set_pix(10'd40, 10'd40, 8'd50, 12'h123, 12'h456);
    tick();
    check("t1_kp1",  a_data,  {10'd40, 10'd40, 8'd50, 12'h123, 12'h456});
    check("t1_lvl1", a_level, 1);
    check("t1_cnt1", a_count, 1);
    set_pix(10'd100, 10'd60, 8'd30, 12'h7FF, 12'h800);
    tick();
    check("t1_kp2",  a_data,  {10'd100, 10'd60, 8'd30, 12'h7FF, 12'h800});
    check("t1_eof2", a_eof,   0);
    set_pix(10'd200, 10'd90, 8'd25, 12'hABC, 12'h001);
    tick();
    check("t1_kp3",  a_data,  {10'd200, 10'd90, 8'd25, 12'hABC, 12'h001});
    check("t1_cnt3", a_count, 3);
    idle_in();
    fin = 1'b1;
    tick();
    fin = 1'b0;
    check("t1_term_busy", a_busy,  1);
    check("t1_term_lvl",  a_level, 0);
    tick();
    check("t1_eof",       a_eof,   1);
    check("t1_tdata",     a_data,  term(10'd3, 10'd0));
    check("t1_idle_busy", a_busy,  0);
    check("t1_hold_cnt",  a_count, 3);
    tick();
    check("t1_drained",   a_valid, 0);

    // MAX_KP=2 cap with four flagged pixels
    do_reset();
    frame_start();
    set_pix(10'd1, 10'd2, 8'd10, 12'h011, 12'h022); tick();
    check("t2_cnt1", b_count, 1);
    set_pix(10'd3, 10'd4, 8'd20, 12'h033, 12'h044); tick();
    check("t2_cnt2", b_count, 2);
    set_pix(10'd5, 10'd6, 8'd30, 12'h055, 12'h066); tick();
    check("t2_cnt3", b_count, 2);
    check("t2_drp3", b_drop,  dexp(10'd1));
    set_pix(10'd7, 10'd8, 8'd40, 12'h077, 12'h088); tick();
    check("t2_drp4", b_drop,  dexp(10'd2));
    check("t2_lvl4", b_level, 2);
    idle_in();
    fin = 1'b1; tick(); fin = 1'b0;
    tick();
    check("t2_lvl_term", b_level, 3);
    check("t2_head", b_data, {10'd1, 10'd2, 8'd10, 12'h011, 12'h022});
    ready = 1'b1;
    tick();
    check("t2_kp2", b_data, {10'd3, 10'd4, 8'd20, 12'h033, 12'h044});
    tick();
    check("t2_eof",   b_eof,  1);
    check("t2_tdata", b_data, term(10'd2, 10'd2));
    tick();
    check("t2_empty", b_valid, 0);

    // DEPTH=4 back-pressure: last slot held for the terminator
    do_reset();
    frame_start();
    set_pix(10'd10, 10'd1, 8'd100, 12'h101, 12'h201); tick();
    set_pix(10'd20, 10'd2, 8'd101, 12'h102, 12'h202); tick();
    set_pix(10'd30, 10'd3, 8'd102, 12'h103, 12'h203); tick();
    check("t3_lvl3", c_level, 3);
    check("t3_drp3", c_drop,  0);
    set_pix(10'd40, 10'd4, 8'd103, 12'h104, 12'h204); tick();
    set_pix(10'd50, 10'd5, 8'd104, 12'h105, 12'h205); tick();
    check("t3_lvl5", c_level, 3);
    check("t3_cnt5", c_count, 3);
    check("t3_drp5", c_drop,  dexp(10'd2));
    idle_in();
    fin = 1'b1; tick(); fin = 1'b0;
    tick();
    check("t3_full", c_level, 4);
    check("t3_busy", c_busy,  0);
    tick();
    check("t3_hold",  c_data, {10'd10, 10'd1, 8'd100, 12'h101, 12'h201});
    check("t3_hold_eof", c_eof, 0);
    ready = 1'b1;
    tick();
    check("t3_pop2", c_data,  {10'd20, 10'd2, 8'd101, 12'h102, 12'h202});
    check("t3_lvlp", c_level, 3);
    tick();
    check("t3_pop3", c_data,  {10'd30, 10'd3, 8'd102, 12'h103, 12'h203});
    tick();
    check("t3_eof",   c_eof,  1);
    check("t3_tdata", c_data, term(10'd3, 10'd2));
    tick();
    check("t3_empty", c_valid, 0);

    // SCORE_MIN=30 boundary: 29 ignored, 30 and 31 kept
    do_reset();
    frame_start();
    set_pix(10'd11, 10'd12, 8'd29, 12'h00A, 12'h00B); tick();
    check("t4_cnt29", c_count, 0);
    check("t4_lvl29", c_level, 0);
    set_pix(10'd13, 10'd14, 8'd30, 12'h00C, 12'h00D); tick();
    check("t4_cnt30", c_count, 1);
    check("t4_kp30",  c_data, {10'd13, 10'd14, 8'd30, 12'h00C, 12'h00D});
    set_pix(10'd15, 10'd16, 8'd31, 12'h00E, 12'h00F); tick();
    check("t4_cnt31", c_count, 2);
    check("t4_drop",  c_drop,  0);

    // Flag with end in the same cycle, then start during the terminator cycle
    do_reset();
    frame_start();
    set_pix(10'd77, 10'd88, 8'd60, 12'hF00, 12'h0F0);
    fin = 1'b1;
    tick();
    idle_in();
    check("t5_cnt",  a_count, 1);
    check("t5_lvl",  a_level, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_newcnt", a_count, 0);
    check("t5_busy",   a_busy,  1);
    check("t5_lvl2",   a_level, 2);
    check("t5_head",   a_data,  {10'd77, 10'd88, 8'd60, 12'hF00, 12'h0F0});
    ready = 1'b1;
    tick();
    check("t5_eof",   a_eof,  1);
    check("t5_tdata", a_data, term(10'd1, 10'd0));
    tick();
    ready = 1'b0;
    check("t5_empty", a_valid, 0);

    // Reset mid-frame with two entries queued
    do_reset();
    frame_start();
    set_pix(10'd5, 10'd5, 8'd9, 12'h001, 12'h002); tick();
    set_pix(10'd6, 10'd6, 8'd9, 12'h003, 12'h004); tick();
    idle_in();
    check("t6_lvl_pre", a_level, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", a_valid, 0);
    check("t6_level", a_level, 0);
    check("t6_count", a_count, 0);
    check("t6_busy",  a_busy,  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
